// File: rtl/board_turn_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_turn_ctrl_if
//  Description : Button/board bundle between the input conditioning logic,
//                the board controller and the display renderers.
//  Revision    : 1.0  initial release
// ============================================================================
interface board_turn_ctrl_if #(
   parameter int CELLS   = 16,
   parameter int VAL_W   = 4,
   parameter int SCORE_W = 4
);
   logic                       move;
   logic                       select;
   logic                       load;
   logic [CELLS*VAL_W-1:0]     load_vals;
   logic [$clog2(CELLS)-1:0]   cursor;
   logic [2*CELLS-1:0]         cell_state;
   logic                       player;
   logic [SCORE_W-1:0]         score0;
   logic [SCORE_W-1:0]         score1;
   logic [7:0]                 counter;
   logic [2:0]                 state;
   logic                       done;

   // Producer of button/board inputs, consumer of board status
   modport master (
      output move, select, load, load_vals,
      input  cursor, cell_state, player, score0, score1, counter, state, done
   );

   // The board controller itself
   modport slave (
      input  move, select, load, load_vals,
      output cursor, cell_state, player, score0, score1, counter, state, done
   );
endinterface
`default_nettype wire

// File: rtl/board_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_turn_ctrl
//  Description : Card-matching game board: cursor movement, card reveal,
//                pair compare, per-player scoring and turn alternation.
//                Optional idle-turn timeout enabled by defining
//                BOARD_TURN_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module board_turn_ctrl #(
   parameter int CELLS    = 16,
   parameter int VAL_W    = 4,
   parameter int SCORE_W  = 4,
   parameter int HIDE_CYC = 50,
   parameter int TURN_CYC = 1000
) (
   input  wire logic          clk,
   input  wire logic          rst,
   board_turn_ctrl_if.slave   bus
);

   localparam int IDX_W = $clog2(CELLS);
   localparam int HT_W  = $clog2(HIDE_CYC + 1);

   localparam logic [1:0] c_cell_hidden   = 2'b00;
   localparam logic [1:0] c_cell_revealed = 2'b01;
   localparam logic [1:0] c_cell_matched  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PICK1 = 3'd1,
      S_PICK2 = 3'd2,
      S_SHOW  = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   state_t                r_state,   w_state_n;
   logic [IDX_W-1:0]      r_cursor,  w_cursor_n;
   logic [2*CELLS-1:0]    r_cells,   w_cells_n;
   logic                  r_player,  w_player_n;
   logic [SCORE_W-1:0]    r_score0,  w_score0_n;
   logic [SCORE_W-1:0]    r_score1,  w_score1_n;
   logic [7:0]            r_counter, w_counter_n;
   logic [IDX_W-1:0]      r_first,   w_first_n;
   logic [HT_W-1:0]       r_hide,    w_hide_n;
   logic                  r_done,    w_done_n;
   logic                  r_prev_move;
   logic                  r_prev_select;
   logic [VAL_W-1:0]      r_vals [CELLS];

   logic                  w_move_p;
   logic                  w_sel_p;
   logic [1:0]            w_cur_cell;
   logic                  w_all_matched;
   logic                  w_turn_exp;

`ifdef BOARD_TURN_TIMEOUT_EN
   localparam int TT_W = $clog2(TURN_CYC + 1);
   logic [TT_W-1:0]       r_turn, w_turn_n;
`else
   logic                  w_unused_turn;
   assign w_unused_turn = (TURN_CYC > 0);
`endif

   function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + SCORE_W'(1);
   endfunction

   function automatic logic [7:0] sat_count(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   assign w_move_p   = bus.move   & ~r_prev_move;
   assign w_sel_p    = bus.select & ~r_prev_select;
   assign w_cur_cell = r_cells[{r_cursor, 1'b0} +: 2];

   // True when the pair under compare (first, cursor) would finish the board
   always_comb begin
      w_all_matched = 1'b1;
      for (int i = 0; i < CELLS; i++) begin
         if (!(r_cells[2*i +: 2] == c_cell_matched ||
               IDX_W'(i) == r_first || IDX_W'(i) == r_cursor))
            w_all_matched = 1'b0;
      end
   end

   // Next-state and next-output logic for the turn FSM
   always_comb begin
      w_state_n   = r_state;
      w_cursor_n  = r_cursor;
      w_cells_n   = r_cells;
      w_player_n  = r_player;
      w_score0_n  = r_score0;
      w_score1_n  = r_score1;
      w_counter_n = r_counter;
      w_first_n   = r_first;
      w_hide_n    = r_hide;
      w_turn_exp  = 1'b0;
`ifdef BOARD_TURN_TIMEOUT_EN
      w_turn_n    = r_turn;
      if ((r_state == S_PICK1 || r_state == S_PICK2) && r_turn != '0) begin
         w_turn_n   = r_turn - TT_W'(1);
         w_turn_exp = (r_turn == TT_W'(1));
      end
`endif

      if (bus.load) begin
         w_state_n   = S_PICK1;
         w_cursor_n  = '0;
         w_cells_n   = '0;
         w_player_n  = 1'b0;
         w_score0_n  = '0;
         w_score1_n  = '0;
         w_counter_n = '0;
         w_first_n   = '0;
         w_hide_n    = '0;
      end else begin
         case (r_state)
            S_PICK1, S_PICK2: begin
               if (w_turn_exp) begin
                  // Turn ran out: hide whatever is face up and pass the turn
                  for (int i = 0; i < CELLS; i++) begin
                     if (r_cells[2*i +: 2] == c_cell_revealed)
                        w_cells_n[2*i +: 2] = c_cell_hidden;
                  end
                  w_player_n  = ~r_player;
                  w_counter_n = sat_count(r_counter);
                  w_state_n   = S_PICK1;
               end else if (w_sel_p) begin
                  // Select wins over a simultaneous move; non-hidden cells ignored
                  if (w_cur_cell == c_cell_hidden) begin
                     if (r_state == S_PICK1) begin
                        w_cells_n[{r_cursor, 1'b0} +: 2] = c_cell_revealed;
                        w_first_n = r_cursor;
                        w_state_n = S_PICK2;
                     end else if (r_vals[r_cursor] == r_vals[r_first]) begin
                        w_cells_n[{r_first,  1'b0} +: 2] = c_cell_matched;
                        w_cells_n[{r_cursor, 1'b0} +: 2] = c_cell_matched;
                        if (r_player) w_score1_n = sat_score(r_score1);
                        else          w_score0_n = sat_score(r_score0);
                        w_counter_n = sat_count(r_counter);
                        w_state_n   = w_all_matched ? S_OVER : S_PICK1;
                     end else begin
                        w_cells_n[{r_cursor, 1'b0} +: 2] = c_cell_revealed;
                        w_counter_n = sat_count(r_counter);
                        w_hide_n    = HT_W'(HIDE_CYC);
                        w_state_n   = S_SHOW;
                     end
                  end
               end else if (w_move_p) begin
                  w_cursor_n = (r_cursor == IDX_W'(CELLS - 1)) ? '0
                                                               : r_cursor + IDX_W'(1);
               end
            end
            S_SHOW: begin
               // Last SHOW cycle: turn the mismatched pair back over
               if (r_hide <= HT_W'(1)) begin
                  w_cells_n[{r_first,  1'b0} +: 2] = c_cell_hidden;
                  w_cells_n[{r_cursor, 1'b0} +: 2] = c_cell_hidden;
                  w_player_n = ~r_player;
                  w_hide_n   = '0;
                  w_state_n  = S_PICK1;
               end else begin
                  w_hide_n   = r_hide - HT_W'(1);
               end
            end
            default: ;
         endcase
      end

`ifdef BOARD_TURN_TIMEOUT_EN
      // Every fresh turn starts with a full timer
      if (w_state_n == S_PICK1 && (r_state != S_PICK1 || bus.load || w_turn_exp))
         w_turn_n = TT_W'(TURN_CYC);
`endif

      w_done_n = (w_state_n == S_OVER);
   end

   // FSM and status registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cursor      <= '0;
         r_cells       <= '0;
         r_player      <= 1'b0;
         r_score0      <= '0;
         r_score1      <= '0;
         r_counter     <= '0;
         r_first       <= '0;
         r_hide        <= '0;
         r_done        <= 1'b0;
         r_prev_move   <= 1'b0;
         r_prev_select <= 1'b0;
      end else begin
         r_state       <= w_state_n;
         r_cursor      <= w_cursor_n;
         r_cells       <= w_cells_n;
         r_player      <= w_player_n;
         r_score0      <= w_score0_n;
         r_score1      <= w_score1_n;
         r_counter     <= w_counter_n;
         r_first       <= w_first_n;
         r_hide        <= w_hide_n;
         r_done        <= w_done_n;
         r_prev_move   <= bus.move;
         r_prev_select <= bus.select;
      end
   end

`ifdef BOARD_TURN_TIMEOUT_EN
   // Idle-turn timer
   always_ff @(posedge clk) begin
      if (!rst) r_turn <= '0;
      else      r_turn <= w_turn_n;
   end
`endif

   // Hidden card values, captured on load
   always_ff @(posedge clk) begin
      for (int i = 0; i < CELLS; i++) begin
         if (!rst)          r_vals[i] <= '0;
         else if (bus.load) r_vals[i] <= bus.load_vals[i*VAL_W +: VAL_W];
      end
   end

   assign bus.cursor     = r_cursor;
   assign bus.cell_state = r_cells;
   assign bus.player     = r_player;
   assign bus.score0     = r_score0;
   assign bus.score1     = r_score1;
   assign bus.counter    = r_counter;
   assign bus.state      = r_state;
   assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_board_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_turn_ctrl
//  Description : Directed, table-driven bench for board_turn_ctrl (4 cells).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_turn_ctrl;

   localparam int CELLS    = 4;
   localparam int VAL_W    = 4;
   localparam int SCORE_W  = 4;
   localparam int HIDE_CYC = 3;
   localparam int TURN_CYC = 20;
   localparam int NVEC     = 41;

   logic clk = 1'b0;
   logic rst = 1'b0;

   board_turn_ctrl_if #(.CELLS(CELLS), .VAL_W(VAL_W), .SCORE_W(SCORE_W)) bus ();

   board_turn_ctrl #(
      .CELLS(CELLS), .VAL_W(VAL_W), .SCORE_W(SCORE_W),
      .HIDE_CYC(HIDE_CYC), .TURN_CYC(TURN_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       mv, sel, ld;
      logic [1:0] cur;
      logic [7:0] cells;
      logic       pl;
      logic [3:0] s0, s1;
      logic [7:0] cnt;
      logic [2:0] st;
      logic       dn;
   } vec_t;

   vec_t tbl [NVEC];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic vec_t v(logic mv, logic sel, logic ld, logic [1:0] cur,
                              logic [7:0] cells, logic pl, logic [3:0] s0,
                              logic [3:0] s1, logic [7:0] cnt, logic [2:0] st,
                              logic dn);
      vec_t r;
      r.mv = mv; r.sel = sel; r.ld = ld; r.cur = cur; r.cells = cells; r.pl = pl;
      r.s0 = s0; r.s1 = s1; r.cnt = cnt; r.st = st; r.dn = dn;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] cur, input logic [7:0] cells,
                          input logic pl, input logic [3:0] s0, input logic [3:0] s1,
                          input logic [7:0] cnt, input logic [2:0] st, input logic dn);
      chk({tag, ".cursor"},     int'(bus.cursor),     int'(cur));
      chk({tag, ".cell_state"}, int'(bus.cell_state), int'(cells));
      chk({tag, ".player"},     int'(bus.player),     int'(pl));
      chk({tag, ".score0"},     int'(bus.score0),     int'(s0));
      chk({tag, ".score1"},     int'(bus.score1),     int'(s1));
      chk({tag, ".counter"},    int'(bus.counter),    int'(cnt));
      chk({tag, ".state"},      int'(bus.state),      int'(st));
      chk({tag, ".done"},       int'(bus.done),       int'(dn));
   endtask

   // One clock of stimulus; outputs are sampled 1 time unit after the edge
   task automatic step(input logic mv, input logic sel, input logic ld);
      bus.move   = mv;
      bus.select = sel;
      bus.load   = ld;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Board {3,5,3,5}, cell0 = 3
      tbl[0]  = v(0,0,1, 0,8'h00,0,0,0,0,1,0);
      tbl[1]  = v(0,0,0, 0,8'h00,0,0,0,0,1,0);
      tbl[2]  = v(1,0,0, 1,8'h00,0,0,0,0,1,0);
      tbl[3]  = v(0,0,0, 1,8'h00,0,0,0,0,1,0);
      tbl[4]  = v(1,0,0, 2,8'h00,0,0,0,0,1,0);
      tbl[5]  = v(0,0,0, 2,8'h00,0,0,0,0,1,0);
      tbl[6]  = v(1,0,0, 3,8'h00,0,0,0,0,1,0);
      tbl[7]  = v(0,0,0, 3,8'h00,0,0,0,0,1,0);
      tbl[8]  = v(1,0,0, 0,8'h00,0,0,0,0,1,0);
      tbl[9]  = v(0,0,0, 0,8'h00,0,0,0,0,1,0);
      tbl[10] = v(1,0,0, 1,8'h00,0,0,0,0,1,0);
      tbl[11] = v(0,0,0, 1,8'h00,0,0,0,0,1,0);
      tbl[12] = v(1,1,0, 1,8'h04,0,0,0,0,2,0);
      tbl[13] = v(0,0,0, 1,8'h04,0,0,0,0,2,0);
      tbl[14] = v(1,0,0, 2,8'h04,0,0,0,0,2,0);
      tbl[15] = v(0,0,0, 2,8'h04,0,0,0,0,2,0);
      tbl[16] = v(1,0,0, 3,8'h04,0,0,0,0,2,0);
      tbl[17] = v(0,0,0, 3,8'h04,0,0,0,0,2,0);
      tbl[18] = v(0,1,0, 3,8'h88,0,1,0,1,1,0);
      tbl[19] = v(0,0,0, 3,8'h88,0,1,0,1,1,0);
      tbl[20] = v(0,1,0, 3,8'h88,0,1,0,1,1,0);
      tbl[21] = v(0,0,0, 3,8'h88,0,1,0,1,1,0);
      tbl[22] = v(1,0,0, 0,8'h88,0,1,0,1,1,0);
      tbl[23] = v(0,0,0, 0,8'h88,0,1,0,1,1,0);
      tbl[24] = v(0,1,0, 0,8'h89,0,1,0,1,2,0);
      tbl[25] = v(0,0,0, 0,8'h89,0,1,0,1,2,0);
      tbl[26] = v(0,1,0, 0,8'h89,0,1,0,1,2,0);
      tbl[27] = v(0,0,0, 0,8'h89,0,1,0,1,2,0);
      tbl[28] = v(1,0,0, 1,8'h89,0,1,0,1,2,0);
      tbl[29] = v(0,0,0, 1,8'h89,0,1,0,1,2,0);
      tbl[30] = v(0,1,0, 1,8'h89,0,1,0,1,2,0);
      tbl[31] = v(0,0,0, 1,8'h89,0,1,0,1,2,0);
      tbl[32] = v(1,0,0, 2,8'h89,0,1,0,1,2,0);
      tbl[33] = v(0,0,0, 2,8'h89,0,1,0,1,2,0);
      tbl[34] = v(0,1,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[35] = v(0,0,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[36] = v(1,0,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[37] = v(0,0,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[38] = v(0,1,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[39] = v(0,0,0, 2,8'hAA,0,2,0,2,4,1);
      tbl[40] = v(0,0,1, 0,8'h00,0,0,0,0,1,0);

      bus.move = 1'b0; bus.select = 1'b0; bus.load = 1'b0;
      bus.load_vals = 16'h5353;

      // Reset held for two cycles
      rst = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_all("reset", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].mv, tbl[i].sel, tbl[i].ld);
         chk_all($sformatf("vec%0d", i), tbl[i].cur, tbl[i].cells, tbl[i].pl,
                 tbl[i].s0, tbl[i].s1, tbl[i].cnt, tbl[i].st, tbl[i].dn);
      end

      // Mismatch on board {1,2,2,1}, SHOW lasts HIDE_CYC cycles
      bus.load_vals = 16'h1221;
      step(0,0,1);
      step(0,1,0); chk_all("mm_sel0", 0, 8'h01, 0, 0, 0, 0, 2, 0);
      step(0,0,0);
      step(1,0,0);
      step(0,0,0);
      step(0,1,0); chk_all("mm_show1", 1, 8'h05, 0, 0, 0, 1, 3, 0);
      step(0,0,0); chk_all("mm_show2", 1, 8'h05, 0, 0, 0, 1, 3, 0);
      step(1,0,0); chk_all("mm_show3", 1, 8'h05, 0, 0, 0, 1, 3, 0);
      step(0,0,0); chk_all("mm_hide",  1, 8'h00, 1, 0, 0, 1, 1, 0);

      // Player 1 matches cells 1 and 2
      step(0,1,0); chk_all("p1_sel1", 1, 8'h04, 1, 0, 0, 1, 2, 0);
      step(0,0,0);
      step(1,0,0);
      step(0,0,0);
      step(0,1,0); chk_all("p1_match", 2, 8'h28, 1, 0, 1, 2, 1, 0);

      // Mid-game reset leaves nothing behind; moves ignored in IDLE
      rst = 1'b0;
      step(0,0,0); chk_all("midrst", 0, 8'h00, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step(1,0,0); chk_all("idle_move", 0, 8'h00, 0, 0, 0, 0, 0, 0);

`ifdef BOARD_TURN_TIMEOUT_EN
      // Idle turn expires: revealed card hidden, turn passes
      bus.load_vals = 16'h5353;
      step(0,0,1);
      step(0,1,0); chk_all("to_sel", 0, 8'h01, 0, 0, 0, 0, 2, 0);
      for (int k = 0; k < TURN_CYC; k++) step(0,0,0);
      chk_all("to_exp", 0, 8'h00, 1, 0, 0, 1, 1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
